logic_unit_pipe: RTL and testbench

//  Parametrised successor of the 1-bit OR/AND/XOR/XNOR gate block.

---
 rtl/logic_unit_pipe.sv | 130 +++++++++++++
 tb/tb_logic_unit_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Op-selected bitwise unit feeding a DEPTH-entry result FIFO with valid/ready handshakes.
// Optional feature: define REDUCE_EN to store and present {^y, |y, &y} per entry on red.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [2:0]       red,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] res;
    logic             push;
    logic             pop;

    logic [WIDTH-1:0] mem_y_q [DEPTH];
    logic [WIDTH-1:0] mem_y_d [DEPTH];
    logic             mem_z_q [DEPTH];
    logic             mem_z_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

    always_comb begin
        res = '0;
        case (op)
            3'b000: res = a & b;
            3'b001: res = a | b;
            3'b010: res = a ^ b;
            3'b011: res = ~(a ^ b);
            3'b100: res = ~(a & b);
            3'b101: res = ~(a | b);
            3'b110: res = ~a;
            3'b111: res = a;
            default: res = '0;
        endcase
    end

    // Handshake flags come only from registered count; in_ready is held low during reset.
    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q != FULL_CNT) & ~rst;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        mem_y_d    = mem_y_q;
        mem_z_d    = mem_z_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        done_cnt_d = done_cnt_q;
        if (push) begin
            mem_y_d[wr_ptr_q] = res;
            mem_z_d[wr_ptr_q] = (res == '0);
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            done_cnt_d = done_cnt_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_y_q    <= '{default: '0};
            mem_z_q    <= '{default: 1'b1};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            done_cnt_q <= '0;
        end else begin
            mem_y_q    <= mem_y_d;
            mem_z_q    <= mem_z_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Head entry is read directly; when empty it simply shows a stale slot.
    assign y        = mem_y_q[rd_ptr_q];
    assign zero     = mem_z_q[rd_ptr_q];
    assign done_cnt = done_cnt_q;

`ifdef REDUCE_EN
    logic [2:0] mem_r_q [DEPTH];
    logic [2:0] mem_r_d [DEPTH];

    always_comb begin
        mem_r_d = mem_r_q;
        if (push) begin
            mem_r_d[wr_ptr_q] = {^res, |res, &res};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_r_q <= '{default: '0};
        end else begin
            mem_r_q <= mem_r_d;
        end
    end

    assign red = mem_r_q[rd_ptr_q];
`else
    assign red = 3'b000;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe (WIDTH=8, DEPTH=2, CNT_W=8).
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic [2:0] red;
    logic [7:0] done_cnt;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    logic_unit_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .zero     (zero),
        .red      (red),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
        logic       exp_zero;
        logic [2:0] exp_red;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] red_exp(input logic [2:0] r);
`ifdef REDUCE_EN
        return r;
`else
        return (r & 3'b000);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned k;

        vecs[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 3'b010};
        vecs[1] = '{3'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 3'b010};
        vecs[2] = '{3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0, 3'b010};
        vecs[3] = '{3'd3, 8'hF0, 8'h3C, 8'h33, 1'b0, 3'b010};
        vecs[4] = '{3'd4, 8'hF0, 8'h3C, 8'hCF, 1'b0, 3'b010};
        vecs[5] = '{3'd5, 8'hF0, 8'h3C, 8'h03, 1'b0, 3'b010};
        vecs[6] = '{3'd6, 8'hF0, 8'h3C, 8'h0F, 1'b0, 3'b010};
        vecs[7] = '{3'd7, 8'hF0, 8'h3C, 8'hF0, 1'b0, 3'b010};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;

        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_y", y, 8'h00);
        check("rst_zero", zero, 1'b1);
        check("rst_red", red, 3'b000);
        check("rst_done", done_cnt, 8'h00);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // All eight ops, streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            a        = vecs[i].a;
            b        = vecs[i].b;
            op       = vecs[i].op;
            check($sformatf("op%0d_in_ready", i), in_ready, 1'b1);
            tick();
            check($sformatf("op%0d_out_valid", i), out_valid, 1'b1);
            check($sformatf("op%0d_y", i), y, vecs[i].exp_y);
            check($sformatf("op%0d_zero", i), zero, vecs[i].exp_zero);
            check($sformatf("op%0d_red", i), red, red_exp(vecs[i].exp_red));
        end
        in_valid = 1'b0;
        tick();
        check("ops_drained", out_valid, 1'b0);
        check("ops_done_cnt", done_cnt, 8'd8);

        // Fill with consumer stalled, third push must be refused
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd7;
        a         = 8'h01;
        tick();
        check("fill1_in_ready", in_ready, 1'b1);
        a = 8'h02;
        tick();
        check("fill2_in_ready", in_ready, 1'b0);
        a = 8'h03;
        tick();
        check("fill3_in_ready", in_ready, 1'b0);
        check("fill3_out_valid", out_valid, 1'b1);
        check("fill3_head", y, 8'h01);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check("full_pop_no_pass", in_ready, 1'b0);
        tick();
        check("full_pop_next_ready", in_ready, 1'b1);
        check("order_second", y, 8'h02);
        check("order_second_valid", out_valid, 1'b1);
        tick();
        check("order_drained", out_valid, 1'b0);
        check("order_done_cnt", done_cnt, 8'd10);

        // Zero result and reduction flags
        in_valid = 1'b1;
        a        = 8'hAA;
        b        = 8'hAA;
        op       = 3'd2;
        tick();
        check("xor_self_y", y, 8'h00);
        check("xor_self_zero", zero, 1'b1);
        check("xor_self_red", red, 3'b000);
        a  = 8'hFF;
        op = 3'd7;
        tick();
        check("pass_ff_y", y, 8'hFF);
        check("pass_ff_zero", zero, 1'b0);
        check("pass_ff_red", red, red_exp(3'b011));
        in_valid = 1'b0;
        tick();
        check("zr_done_cnt", done_cnt, 8'd12);

        // Counter wrap: continuous push/pop until done_cnt hits FF
        in_valid = 1'b1;
        a        = 8'h5A;
        op       = 3'd7;
        k        = 0;
        for (int i = 1; i <= 400; i++) begin
            tick();
            if (done_cnt == 8'hFF) begin
                k = i;
                break;
            end
        end
        check("wrap_cycles_to_ff", k, 244);
        tick();
        check("wrap_to_zero", done_cnt, 8'h00);
        in_valid = 1'b0;
        tick();
        check("wrap_after", done_cnt, 8'h01);
        check("wrap_drained", out_valid, 1'b0);

        // Asynchronous reset with two entries queued
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = 8'hC3;
        tick();
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 1'b0);
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_head", y, 8'hC3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 1'b0);
        check("async_rst_done", done_cnt, 8'h00);
        check("async_rst_in_ready", in_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_in_ready", in_ready, 1'b1);
        check("rel_y", y, 8'h00);
        check("rel_zero", zero, 1'b1);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        check("rel_no_stale", out_valid, 1'b0);
        check("rel_done", done_cnt, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
